// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encodings and default width for the serial subtractor
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit full subtractor, x - y - bin
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, one bit per clock
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow_out
);

  localparam int CNT_W = (N > 2) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

  state_t           state_q, state_d;
  logic [N-1:0]     a_sr, b_sr, res_sr;
  logic [N-1:0]     diff_q;
  logic             bw_q, borrow_q;
  logic [CNT_W-1:0] cnt_q;
  logic             bit_d, bit_bout;
  logic             last_bit;

  full_subtractor u_fs (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (bw_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  assign last_bit = (cnt_q == LAST_BIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_bit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Published result only changes on the edge that completes the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      bw_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            bw_q  <= 1'b0;
            cnt_q <= '0;
          end
        end
        ST_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {bit_d, res_sr[N-1:1]};
          bw_q   <= bit_bout;
          cnt_q  <= last_bit ? '0 : cnt_q + 1'b1;
          if (last_bit) begin
            diff_q   <= {bit_d, res_sr[N-1:1]};
            borrow_q <= bit_bout;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor against an arithmetic reference
module tb_serial_subtractor;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy, done, borrow_out;
  logic [N-1:0] diff;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_count = 0;
  int last_done_cyc = 0;
  logic [N:0] sb[$];

  serial_subtractor #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [N:0] ref_sub(input int x, input int y);
    int r;
    r = x - y;
    if (r < 0) r = r + (1 << N);
    return {(x < y) ? 1'b1 : 1'b0, r[N-1:0]};
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      logic [N:0] exp;
      done_count++;
      last_done_cyc = cyc;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got diff %0d with no expected result", diff);
      end else begin
        exp = sb.pop_front();
        check("result_diff", int'(diff), int'(exp[N-1:0]));
        check("result_borrow", int'(borrow_out), int'(exp[N]));
      end
    end
  end

  task automatic run_op(input int x, input int y);
    int lat, busy_cnt;
    logic [N-1:0] held;
    @(negedge clk);
    start = 1'b1;
    a = N'(x);
    b = N'(y);
    sb.push_back(ref_sub(x, y));
    @(negedge clk);
    start = 1'b0;
    a = N'($urandom);
    b = N'($urandom);
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check("done_latency", lat, N + 1);
    check("busy_cycles", busy_cnt, N);
    held = diff;
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("diff_hold", int'(diff), int'(held));
  endtask

  initial begin
    int base, t1;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_diff", int'(diff), 0);
    check("reset_borrow", int'(borrow_out), 0);
    rst = 1'b0;

    run_op(100, 58);
    run_op(5, 10);
    run_op(0, 1);
    run_op(8'hAA, 8'hAA);
    run_op(255, 0);

    // Re-pulsed start mid-RUN must be ignored.
    base = done_count;
    @(negedge clk);
    start = 1'b1; a = 8'd100; b = 8'd58;
    sb.push_back(ref_sub(100, 58));
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'd1; b = 8'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (N + 4) @(negedge clk);
    check("midrun_done_count", done_count - base, 1);

    // Reset on the 4th RUN cycle aborts without a result.
    base = done_count;
    @(negedge clk);
    start = 1'b1; a = 8'd100; b = 8'd58;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_diff", int'(diff), 0);
    check("abort_borrow", int'(borrow_out), 0);
    repeat (N + 3) @(negedge clk);
    check("abort_no_done", done_count - base, 0);
    run_op(7, 3);

    // Start held high: two operations back to back, N+2 cycles apart.
    base = done_count;
    @(negedge clk);
    start = 1'b1; a = 8'd9; b = 8'd2;
    sb.push_back(ref_sub(9, 2));
    @(negedge clk);
    a = 8'd2; b = 8'd9;
    sb.push_back(ref_sub(2, 9));
    t1 = 0;
    while (done_count - base < 1 && t1 < 40) begin @(negedge clk); t1++; end
    t1 = last_done_cyc;
    repeat (3) @(negedge clk);
    start = 1'b0;
    begin
      int w = 0;
      while (done_count - base < 2 && w < 40) begin @(negedge clk); w++; end
    end
    check("b2b_done_count", done_count - base, 2);
    check("b2b_spacing", last_done_cyc - t1, N + 2);

    for (int i = 0; i < 20; i++) begin
      int x, y;
      x = int'($urandom_range(0, (1 << N) - 1));
      y = int'($urandom_range(0, (1 << N) - 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(x, y);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter N, default 8, meaning operand/result width in bits (N >= 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port a  input  N  minuend, unsigned; captured on the edge that accepts start.
REQ-006 SHALL have port b  input  N  subtrahend, unsigned; captured on the edge that accepts start.
REQ-007 SHALL have port busy  output  1  high while bits are being processed (RUN).
REQ-008 SHALL have port done  output  1  one-cycle pulse marking a new valid result.
REQ-009 SHALL have port diff  output  N  last completed result, (a - b) mod 2^N.
REQ-010 SHALL have port borrow_out  output  1  last completed borrow: 1 iff a < b unsigned.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-012 IDLE with start=1 SHALL load a and b into shift registers, clear the borrow flop and bit counter, and go to RUN; start=0 stays IDLE.
REQ-013 Each RUN edge SHALL process one bit, LSB first: d = a0 ^ b0 ^ bw; bw_next = (~a0 & b0) | (~(a0 ^ b0) & bw).
REQ-014 Each RUN edge SHALL shift both operand registers right by one, shift d into the MSB of an internal result register, and increment the counter.
REQ-015 RUN SHALL last exactly N edges; the edge processing bit N-1 (counter == N-1) SHALL move to DONE.
REQ-016 On the edge entering DONE, diff SHALL load the full internal result and borrow_out the final borrow.
REQ-017 done SHALL be high exactly during the DONE cycle: first visible after edge N following the edge that accepted start; DONE returns to IDLE unconditionally on the next edge.
REQ-018 busy SHALL be high exactly while in RUN (N cycles).
REQ-019 diff and borrow_out SHALL hold their values from the end of DONE until the next DONE; partial results SHALL never appear on them.
REQ-020 start SHALL be ignored in RUN and DONE; operands are not re-captured; start held high through DONE is accepted on the first IDLE edge.
REQ-021 Back-to-back operation SHALL give one result per N+2 cycles with start held high.
REQ-022 The bit counter SHALL be ceil(log2(N)) bits wide and SHALL not wrap within an operation.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, busy=0, done=0, diff=0, borrow_out=0, and clear counter, borrow flop, and shift registers.
REQ-024 rst SHALL take priority over start and over any in-flight operation; an aborted operation SHALL produce no done pulse and no result update.
REQ-025 After rst deasserts, the first edge with start=1 SHALL be accepted normally.

Structure
REQ-026 A shared package SHALL hold the FSM state encodings (IDLE, RUN, DONE) and the default width constant 8.
REQ-027 The per-bit logic SHALL be a sub-module full_subtractor (inputs x, y, bin; outputs d, bout), instantiated once in the datapath.
REQ-028 The FSM, counter, and shift registers SHALL be in serial_subtractor; the block has no other sub-modules.

Verification
REQ-029 a=100, b=58, start pulse -> busy high 8 cycles, done pulse, diff=42, borrow_out=0.
REQ-030 a=5, b=10 -> diff=251, borrow_out=1; a=0, b=1 -> diff=255, borrow_out=1.
REQ-031 a=8'hAA, b=8'hAA -> diff=0, borrow_out=0; a=255, b=0 -> diff=255, borrow_out=0.
REQ-032 start re-pulsed with a=1, b=1 mid-RUN of a=100, b=58 -> ignored; result 42/0; exactly one done pulse.
REQ-033 rst asserted on the 4th RUN cycle -> no done pulse, diff=0, borrow_out=0, IDLE; then a=7, b=3 -> diff=4.
REQ-034 start held high over two operations (9-2, then 2-9) -> done pulses 10 cycles apart, results 7/0 then 249/1.
